// File: rtl/vec_magnitude_if.sv
// Handshake bundle for vec_magnitude: start/operands in, busy/done/result out.
// The sumsq field exists only when VEC_MAG_SUMSQ_EN is defined.
interface vec_magnitude_if;
  logic               start;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic               busy;
  logic               done;
  logic [15:0]        result;
`ifdef VEC_MAG_SUMSQ_EN
  logic [31:0]        sumsq;
`endif

`ifdef VEC_MAG_SUMSQ_EN
  modport master (output start, a, b, input busy, done, result, sumsq);
  modport slave  (input start, a, b, output busy, done, result, sumsq);
`else
  modport master (output start, a, b, input busy, done, result);
  modport slave  (input start, a, b, output busy, done, result);
`endif
endinterface

// File: rtl/vec_magnitude.sv
// Multi-cycle floor(sqrt(a^2 + b^2)) unit: shift-add squarer feeding a combinational
// integer square root. Optional macro VEC_MAG_SUMSQ_EN exposes the final sum of squares.

// Restoring digit-by-digit integer square root, two radicand bits per iteration.
module sqrt32to16 (
  input  logic [31:0] i_radicand,
  output logic [15:0] o_root
);
  always_comb begin
    logic [17:0] w_rem;
    logic [17:0] w_trial;
    logic [15:0] w_root;
    w_rem   = 18'd0;
    w_trial = 18'd0;
    w_root  = 16'd0;
    for (int i = 15; i >= 0; i--) begin
      w_rem   = {w_rem[15:0], i_radicand[2*i +: 2]};
      w_trial = {w_root, 2'b01};
      if (w_rem >= w_trial) begin
        w_rem  = w_rem - w_trial;
        w_root = {w_root[14:0], 1'b1};
      end else begin
        w_root = {w_root[14:0], 1'b0};
      end
    end
    o_root = w_root;
  end
endmodule

module vec_magnitude (
  input  logic           clk,
  input  logic           reset,
  vec_magnitude_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SQ_A = 2'd1, SQ_B = 2'd2, ROOT = 2'd3} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_abs_a, w_abs_a_nxt;
  logic [15:0] r_abs_b, w_abs_b_nxt;
  logic [31:0] r_acc, w_acc_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic [15:0] r_result, w_result_nxt;
`ifdef VEC_MAG_SUMSQ_EN
  logic [31:0] r_sumsq, w_sumsq_nxt;
`endif

  logic [15:0] w_in_abs_a;
  logic [15:0] w_in_abs_b;
  logic [15:0] w_mcand;
  logic [31:0] w_partial;
  logic [15:0] w_root;

  // |-32768| wraps to 16'h8000, which is exactly the unsigned magnitude we want.
  assign w_in_abs_a = bus.a[15] ? (16'(~bus.a) + 16'd1) : 16'(bus.a);
  assign w_in_abs_b = bus.b[15] ? (16'(~bus.b) + 16'd1) : 16'(bus.b);

  assign w_mcand   = (r_state == SQ_A) ? r_abs_a : r_abs_b;
  assign w_partial = w_mcand[r_cnt] ? ({16'd0, w_mcand} << r_cnt) : 32'd0;

  sqrt32to16 u_sqrt (
    .i_radicand (r_acc),
    .o_root     (w_root)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_abs_a_nxt  = r_abs_a;
    w_abs_b_nxt  = r_abs_b;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
`ifdef VEC_MAG_SUMSQ_EN
    w_sumsq_nxt  = r_sumsq;
`endif
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_abs_a_nxt = w_in_abs_a;
          w_abs_b_nxt = w_in_abs_b;
          w_acc_nxt   = 32'd0;
          w_cnt_nxt   = 4'd0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = SQ_A;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SQ_A, SQ_B: begin
        w_acc_nxt = r_acc + w_partial;
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = (r_state == SQ_A) ? SQ_B : ROOT;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ROOT: begin
        w_result_nxt = w_root;
`ifdef VEC_MAG_SUMSQ_EN
        w_sumsq_nxt  = r_acc;
`endif
        w_done_nxt   = 1'b1;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_abs_a  <= 16'd0;
      r_abs_b  <= 16'd0;
      r_acc    <= 32'd0;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 16'd0;
`ifdef VEC_MAG_SUMSQ_EN
      r_sumsq  <= 32'd0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_abs_a  <= w_abs_a_nxt;
      r_abs_b  <= w_abs_b_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
`ifdef VEC_MAG_SUMSQ_EN
      r_sumsq  <= w_sumsq_nxt;
`endif
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
`ifdef VEC_MAG_SUMSQ_EN
  assign bus.sumsq  = r_sumsq;
`endif
endmodule

// File: tb/tb_vec_magnitude.sv
// Directed, table-driven bench for vec_magnitude plus hand-written handshake sequences.
module tb_vec_magnitude;
  logic clk = 1'b0;
  logic reset;

  vec_magnitude_if vif ();

  vec_magnitude dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic [15:0]        exp_root;
    logic [31:0]        exp_sq;
  } vec_t;

  vec_t vecs [9];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and checks the full 33-cycle busy/done timeline.
  task automatic run_op(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic [15:0] exp_root, input logic [31:0] exp_sq);
    int bad;
    vif.start = 1'b1;
    vif.a     = a;
    vif.b     = b;
    tick();
    vif.start = 1'b0;
    check("busy_after_accept", {31'd0, vif.busy}, 32'd1);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (vif.done !== 1'b0 || vif.busy !== 1'b1) bad++;
    end
    check("busy_window", bad, 32'd0);
    tick();
    check("done_e33", {31'd0, vif.done}, 32'd1);
    check("busy_e33", {31'd0, vif.busy}, 32'd0);
    check("result", {16'd0, vif.result}, {16'd0, exp_root});
`ifdef VEC_MAG_SUMSQ_EN
    check("sumsq", vif.sumsq, exp_sq);
`endif
    tick();
    check("done_e34", {31'd0, vif.done}, 32'd0);
    check("result_hold", {16'd0, vif.result}, {16'd0, exp_root});
  endtask

  initial begin
    int bad;
    vecs[0] = '{16'sd3,      16'sd4,      16'd5,     32'd25};
    vecs[1] = '{-16'sd32768, -16'sd32768, 16'd46340, 32'h8000_0000};
    vecs[2] = '{-16'sd7,     16'sd24,     16'd25,    32'd625};
    vecs[3] = '{16'sd32767,  16'sd0,      16'd32767, 32'd1073676289};
    vecs[4] = '{-16'sd1,     16'sd1,      16'd1,     32'd2};
    vecs[5] = '{16'sd1000,   -16'sd2000,  16'd2236,  32'd5000000};
    vecs[6] = '{16'sd32767,  16'sd32767,  16'd46339, 32'd2147352578};
    vecs[7] = '{16'sd0,      -16'sd32768, 16'd32768, 32'd1073741824};
    vecs[8] = '{16'sd6,      16'sd8,      16'd10,    32'd100};

    reset     = 1'b1;
    vif.start = 1'b0;
    vif.a     = 16'sd0;
    vif.b     = 16'sd0;
    tick();
    tick();
    check("rst_busy", {31'd0, vif.busy}, 32'd0);
    check("rst_done", {31'd0, vif.done}, 32'd0);
    check("rst_result", {16'd0, vif.result}, 32'd0);
`ifdef VEC_MAG_SUMSQ_EN
    check("rst_sumsq", vif.sumsq, 32'd0);
`endif
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_root, vecs[i].exp_sq);
      tick();
    end

    // Back-to-back: second start issued in the done cycle of the first.
    vif.start = 1'b1;
    vif.a     = 16'sd0;
    vif.b     = 16'sd0;
    tick();
    vif.start = 1'b0;
    for (int k = 1; k <= 32; k++) tick();
    tick();
    check("b2b_done1", {31'd0, vif.done}, 32'd1);
    check("b2b_result1", {16'd0, vif.result}, 32'd0);
    vif.start = 1'b1;
    vif.a     = 16'sd1;
    vif.b     = 16'sd1;
    tick();
    vif.start = 1'b0;
    check("b2b_done_drop", {31'd0, vif.done}, 32'd0);
    check("b2b_busy2", {31'd0, vif.busy}, 32'd1);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (vif.result !== 16'd0 || vif.done !== 1'b0) bad++;
    end
    check("b2b_hold", bad, 32'd0);
    tick();
    check("b2b_done2", {31'd0, vif.done}, 32'd1);
    check("b2b_result2", {16'd0, vif.result}, 32'd1);
    tick();

    // Start pulsed at E10 while busy must be ignored.
    vif.start = 1'b1;
    vif.a     = -16'sd7;
    vif.b     = 16'sd24;
    tick();
    vif.start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    vif.start = 1'b1;
    vif.a     = 16'sd100;
    vif.b     = 16'sd100;
    tick();
    vif.start = 1'b0;
    bad = 0;
    for (int k = 11; k <= 32; k++) begin
      tick();
      if (vif.done !== 1'b0) bad++;
    end
    check("ign_no_early_done", bad, 32'd0);
    tick();
    check("ign_done", {31'd0, vif.done}, 32'd1);
    check("ign_result", {16'd0, vif.result}, 32'd25);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (vif.done !== 1'b0 || vif.busy !== 1'b0) bad++;
    end
    check("ign_single_done", bad, 32'd0);

    // Reset at E20 aborts the operation.
    vif.start = 1'b1;
    vif.a     = 16'sd300;
    vif.b     = 16'sd400;
    tick();
    vif.start = 1'b0;
    for (int k = 1; k <= 19; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, vif.busy}, 32'd0);
    check("abort_done", {31'd0, vif.done}, 32'd0);
    check("abort_result", {16'd0, vif.result}, 32'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (vif.done !== 1'b0 || vif.busy !== 1'b0) bad++;
    end
    check("abort_quiet", bad, 32'd0);
    run_op(16'sd6, 16'sd8, 16'd10, 32'd100);
    tick();

    // Reset and start on the same edge: start dropped.
    reset     = 1'b1;
    vif.start = 1'b1;
    vif.a     = 16'sd3;
    vif.b     = 16'sd4;
    tick();
    reset     = 1'b0;
    vif.start = 1'b0;
    check("rs_result", {16'd0, vif.result}, 32'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (vif.done !== 1'b0 || vif.busy !== 1'b0) bad++;
    end
    check("rs_quiet", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_magnitude.md
# vec_magnitude

Multi-cycle vector-magnitude unit: computes floor(sqrt(a² + b²)) for two signed 16-bit operands. It is the stage directly upstream of the combinational `sqrt32to16` block, which it instantiates. A sequential shift-add squarer builds the 32-bit sum of squares and feeds it to `sqrt32to16`, then the unit registers the 16-bit root. It sits beside the ALU and runs under a start/done handshake, so the CPU controller can stall on `busy`.

## Interface
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only when `busy` = 0.
- `a`  in  16  signed operand, two's complement; captured on an accepted `start`.
- `b`  in  16  signed operand, two's complement; captured on an accepted `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  single-cycle completion pulse.
- `result`  out  16  unsigned floor(sqrt(a²+b²)); holds its value until the next completion.
- `sumsq`  out  32  exists only with `VEC_MAG_SUMSQ_EN` (see Configuration).

## Operation
- States: IDLE, SQ_A, SQ_B, ROOT.
- IDLE, `start` = 1:
  - Latch |a| and |b| as 16-bit unsigned values. |-32768| = 32768 is legal.
  - Clear the 32-bit accumulator `acc` and the 4-bit iteration counter.
  - Set `busy`. Go to SQ_A.
- SQ_A: one shift-add step per cycle, 16 steps, multiplier bits LSB first.
  - Step i: if bit i of |a| is 1, `acc` += |a| << i.
  - After step 15, go to SQ_B and reset the counter.
- SQ_B: the same 16 steps for |b|, accumulating into the same `acc`. After step 15, go to ROOT.
- ROOT: `result` <= sqrt32to16(`acc`), `done` <= 1, `busy` <= 0. Next state is IDLE.
- Width rules:
  - The maximum sum is 2·32768² = 2³¹. It fits in 32 bits unsigned with no overflow.
  - The maximum root is 46340. It fits in 16 bits with no saturation.
- `start` is ignored while `busy` = 1. No queueing. Operands change only on an accepted start.
- `done` = 1 in IDLE; `start` in that same cycle is accepted normally, which gives back-to-back operation.
- Reset values: `busy` = 0, `done` = 0, `result` = 0, `acc` = 0, state = IDLE.
- Reset mid-operation aborts the operation. No `done` is produced. All outputs return to their reset values.
- `reset` and `start` on the same edge: reset wins and the start is dropped.

## Timing
- Let E0 be the edge that accepts `start`.
- Edges E1–E16: SQ_A steps.
- Edges E17–E32: SQ_B steps.
- Edge E33: `result` updates and `done` rises.
- Edge E34: `done` falls.
- `busy` is high from E0 to E33.
- Latency: 33 cycles from accept to `done`.
- Throughput: one operation per 34 cycles at most.
- `result` is valid from E33 and stable until the next E33.
- The combinational path `acc` → `sqrt32to16` → `result` register is the critical path. No other output is combinational.

## Configuration
- Macro: `VEC_MAG_SUMSQ_EN`.
- Defined:
  - Adds the `sumsq` output port, registered at E33 alongside `result` with the final `acc` value.
  - `sumsq` resets to 0 and holds until the next completion.
- Undefined:
  - The port is absent.
  - `acc` has no fan-out other than the sqrt stage.
  - Behaviour and timing are otherwise identical.

## Test plan
- a=3, b=4, one `start` pulse → `busy` for 33 cycles, then `done` for 1 cycle with `result`=5. With the macro defined, `sumsq`=25.
- a=-32768, b=-32768 → `result`=46340. With the macro defined, `sumsq`=0x80000000.
- a=0, b=0, followed by a=1, b=1 started in the `done` cycle → `result`=0, then `result`=1 exactly 34 cycles later. `result` holds 0 between the two completions.
- a=-7, b=24, then a second `start` with a=100, b=100 pulsed at E10 → second start ignored; a single `done` at E33 with `result`=25.
- a=300, b=400, `reset` asserted at E20 → no `done`. `busy`=0 and `result`=0 the cycle after reset. A fresh a=6, b=8 then gives `result`=10.
- `reset` and `start` asserted on the same edge → `busy` stays 0 and no `done` occurs within 40 cycles.
